// File: rtl/bit_serial_add_ctrl.sv
// ============================================================================
// Module   : bit_serial_add_ctrl
// Brief    : Bit-serial W-bit adder/subtractor sequencer using one full adder,
//            LSB first, with a start/done handshake. Optional subtract support
//            is compiled in when BITSERIAL_SUB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         overflow
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] c_last_cnt = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W-1:0]  r_op_a;
  logic [W-1:0]  r_op_b;
  logic [W-1:0]  r_acc;
  logic          r_carry;
  logic [CW-1:0] r_cnt;

  logic [W-1:0]  w_acc_next;
  logic          w_bb;
  logic          w_sum;
  logic          w_carry_out;
  logic          w_carry_init;

`ifdef BITSERIAL_SUB_EN
  // Subtract is A + ~B + 1: invert B bit-by-bit and seed the carry with 1.
  logic r_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_sub <= sub;
    end
  end

  assign w_bb         = r_op_b[0] ^ r_sub;
  assign w_carry_init = sub;
`else
  logic w_unused_sub;

  assign w_unused_sub = sub;
  assign w_bb         = r_op_b[0];
  assign w_carry_init = 1'b0;
`endif

  assign w_sum       = r_op_a[0] ^ w_bb ^ r_carry;
  assign w_carry_out = (r_op_a[0] & w_bb) | (r_op_a[0] & r_carry) | (w_bb & r_carry);

  generate
    if (W == 1) begin : g_acc_w1
      assign w_acc_next = w_sum;
    end else begin : g_acc_wide
      assign w_acc_next = {w_sum, r_acc[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= b;
            r_cnt   <= '0;
            r_carry <= w_carry_init;
            busy    <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_acc   <= w_acc_next;
          r_carry <= w_carry_out;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == c_last_cnt) begin
            // r_carry here is the carry into the MSB.
            result   <= w_acc_next;
            cout     <= w_carry_out;
            overflow <= r_carry ^ w_carry_out;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_add_ctrl.sv
// ============================================================================
// Module   : tb_bit_serial_add_ctrl
// Brief    : Self-checking bench for bit_serial_add_ctrl (W=8 and W=1 instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_add_ctrl;

`ifdef BITSERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       sub;
  logic       busy, done, cout, overflow;
  logic [7:0] result;

  logic       start1;
  logic [0:0] a1, b1;
  logic       sub1;
  logic       busy1, done1, cout1, overflow1;
  logic [0:0] result1;

  int n_checks = 0;
  int n_err    = 0;
  logic [7:0] prev_res = 8'd0;

  always #5 clk = ~clk;

  bit_serial_add_ctrl #(.W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .sub(sub),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  bit_serial_add_ctrl #(.W(1)) u_dut_w1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .sub(sub1),
    .busy(busy1), .done(done1), .result(result1), .cout(cout1), .overflow(overflow1)
  );

  typedef struct {
    logic [7:0] va;
    logic [7:0] vb;
    logic       vsub;
    logic [7:0] exp_res;
    logic       exp_cout;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on W=8 operands.
  task automatic model(input logic [7:0] ma, input logic [7:0] mb, input logic ms,
                       output logic [7:0] r, output logic co, output logic ov);
    logic [8:0] sum;
    logic [7:0] bb;
    logic       ci;
    bb = mb;
    ci = 1'b0;
    if (ms && SUB_EN) begin
      bb = ~mb;
      ci = 1'b1;
    end
    sum = {1'b0, ma} + {1'b0, bb} + {8'd0, ci};
    r   = sum[7:0];
    co  = sum[8];
    ov  = (ma[7] == bb[7]) && (r[7] != ma[7]);
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input logic [7:0] er, input logic ec, input logic eo,
                        input string nm, input bit disturb);
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    check({nm, " busy_after_start"}, {62'd0, busy, done}, 64'd2);
    if (!disturb) start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (disturb) begin
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
      end
      @(posedge clk); #1;
      if (i < 8) begin
        if (!(busy === 1'b1 && done === 1'b0 && result === prev_res))
          check({nm, " run_state"}, {54'd0, busy, done, result}, {54'd0, 1'b1, 1'b0, prev_res});
      end else begin
        check({nm, " done_pulse"}, {62'd0, busy, done}, 64'd1);
        check({nm, " result"}, {54'd0, result, cout, overflow}, {54'd0, er, ec, eo});
      end
    end
    prev_res = er;
    if (!disturb) begin
      @(posedge clk); #1;
      check({nm, " done_one_cycle"}, {62'd0, busy, done}, 64'd0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb, er;
    logic       rs, ec, eo;
    bit         seen_done;

    vecs[0] = '{8'd5,   8'd3,   1'b0, 8'd8,   1'b0, 1'b0};
    vecs[1] = '{8'd255, 8'd1,   1'b0, 8'd0,   1'b1, 1'b0};
    vecs[2] = '{8'd127, 8'd1,   1'b0, 8'd128, 1'b0, 1'b1};
    vecs[3] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};
    vecs[4] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0};
`ifdef BITSERIAL_SUB_EN
    vecs[5] = '{8'd5,   8'd3,   1'b1, 8'd2,   1'b1, 1'b0};
    vecs[6] = '{8'd3,   8'd5,   1'b1, 8'd254, 1'b0, 1'b0};
    vecs[7] = '{8'd128, 8'd1,   1'b1, 8'd127, 1'b1, 1'b1};
`else
    vecs[5] = '{8'd5,   8'd3,   1'b1, 8'd8,   1'b0, 1'b0};
    vecs[6] = '{8'd3,   8'd5,   1'b1, 8'd8,   1'b0, 1'b0};
    vecs[7] = '{8'd128, 8'd1,   1'b1, 8'd129, 1'b0, 1'b0};
`endif

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {53'd0, busy, done, result, cout, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].va, vecs[i].vb, vecs[i].vsub, vecs[i].exp_res,
             vecs[i].exp_cout, vecs[i].exp_ov, $sformatf("vec%0d", i), 1'b0);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      model(ra, rb, rs, er, ec, eo);
      run_op(ra, rb, rs, er, ec, eo, $sformatf("rand%0d", i), 1'b0);
    end

    // Start held and operands scrambled during RUN: first result unaffected,
    // second op only begins after the DONE -> IDLE return.
    run_op(8'd40, 8'd2, 1'b0, 8'd42, 1'b0, 1'b0, "held_start", 1'b1);
    @(negedge clk);
    a = 8'd10; b = 8'd20; sub = 1'b0;
    @(posedge clk); #1;
    check("held_start idle_gap", {62'd0, busy, done}, 64'd0);
    @(posedge clk); #1;
    check("held_start reaccept", {62'd0, busy, done}, 64'd2);
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("held_start second_result", {53'd0, done, result, cout, overflow}, {53'd0, 1'b1, 8'd30, 1'b0, 1'b0});
    prev_res = 8'd30;
    @(posedge clk); #1;

    // Async reset mid-RUN at cnt=4.
    @(negedge clk);
    a = 8'd100; b = 8'd50; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_run_reset", {53'd0, busy, done, result, cout, overflow}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    check("no_done_after_reset", {63'd0, seen_done}, 64'd0);
    prev_res = 8'd0;
    run_op(8'd5, 8'd3, 1'b0, 8'd8, 1'b0, 1'b0, "after_reset", 1'b0);

    // W=1: single RUN edge, carry into MSB is the initial carry.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; sub1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("w1 busy", {62'd0, busy1, done1}, 64'd2);
    @(posedge clk); #1;
    check("w1 done", {59'd0, busy1, done1, result1, cout1, overflow1}, {59'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    @(posedge clk); #1;
    check("w1 done_clear", {62'd0, busy1, done1}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
